// File: rtl/uart_block_serializer.sv
// uart_block_serializer: accepts one BLK_BYTES-wide block over valid/ready and
// streams it to the UART transmitter byte port as header, data bytes MSB-first,
// and (when TX_CSUM_EN is defined) a trailing XOR checksum of the data bytes.
// Optional feature macro: TX_CSUM_EN (checksum byte and csum register).
module uart_block_serializer #(
   parameter int unsigned BLK_BYTES = 16,
   parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [8*BLK_BYTES-1:0] blk_data,
   input  logic                   blk_valid,
   output logic                   blk_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_require,
   output logic                   busy,
   output logic                   frame_done
);

   localparam int unsigned BLK_W = 8 * BLK_BYTES;
   localparam int unsigned IDX_W = $clog2(BLK_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
`ifdef TX_CSUM_EN
      CSUM = 2'd3,
`endif
      DATA = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [BLK_W-1:0]   shreg_q, shreg_d;
   logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               blk_ready_q, blk_ready_d;
   logic               busy_q, busy_d;
   logic               frame_done_q, frame_done_d;
`ifdef TX_CSUM_EN
   logic [7:0]         csum_q, csum_d;
`endif
   logic               xfer_c;

   assign xfer_c = tx_valid_q & tx_require;

   // Next-state and next-output decode; all outputs come from registers.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      byte_idx_d   = byte_idx_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      blk_ready_d  = blk_ready_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
`ifdef TX_CSUM_EN
      csum_d       = csum_q;
`endif
      case (state_q)
         IDLE: begin
            if (blk_valid && blk_ready_q) begin
               shreg_d     = blk_data;
               tx_data_d   = HDR_BYTE;
               tx_valid_d  = 1'b1;
               byte_idx_d  = '0;
`ifdef TX_CSUM_EN
               csum_d      = 8'h00;
`endif
               blk_ready_d = 1'b0;
               busy_d      = 1'b1;
               state_d     = HDR;
            end
         end
         HDR: begin
            if (xfer_c) begin
               tx_data_d = shreg_q[BLK_W-1 -: 8];
               shreg_d   = {shreg_q[BLK_W-9:0], 8'h00};
               state_d   = DATA;
            end
         end
         DATA: begin
            if (xfer_c) begin
`ifdef TX_CSUM_EN
               csum_d = csum_q ^ tx_data_q;
`endif
               if (byte_idx_q == LAST_IDX) begin
`ifdef TX_CSUM_EN
                  tx_data_d = csum_q ^ tx_data_q;
                  state_d   = CSUM;
`else
                  tx_valid_d   = 1'b0;
                  blk_ready_d  = 1'b1;
                  busy_d       = 1'b0;
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
`endif
               end else begin
                  byte_idx_d = byte_idx_q + IDX_W'(1);
                  tx_data_d  = shreg_q[BLK_W-1 -: 8];
                  shreg_d    = {shreg_q[BLK_W-9:0], 8'h00};
               end
            end
         end
`ifdef TX_CSUM_EN
         CSUM: begin
            if (xfer_c) begin
               tx_valid_d   = 1'b0;
               blk_ready_d  = 1'b1;
               busy_d       = 1'b0;
               frame_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         byte_idx_q   <= '0;
         tx_data_q    <= 8'h00;
         tx_valid_q   <= 1'b0;
         blk_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef TX_CSUM_EN
         csum_q       <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         byte_idx_q   <= byte_idx_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         blk_ready_q  <= blk_ready_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
`ifdef TX_CSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign blk_ready  = blk_ready_q;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_block_serializer.sv
// Bench for uart_block_serializer: random and directed blocks, reference frames
// built from the frame-layout rules, streams captured at the transmitter port.
module tb_uart_block_serializer;

   localparam int unsigned NB = 16;
`ifdef TX_CSUM_EN
   localparam int FL = NB + 2;
`else
   localparam int FL = NB + 1;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [8*NB-1:0] blk_data = '0;
   logic            blk_valid = 1'b0;
   logic            blk_ready;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_require = 1'b0;
   logic            busy;
   logic            frame_done;

   uart_block_serializer #(.BLK_BYTES(NB), .HDR_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .blk_data(blk_data), .blk_valid(blk_valid),
      .blk_ready(blk_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_require(tx_require), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [7:0]      got[$];
   logic [7:0]      exp[$];
   logic [8*NB-1:0] pend[$];
   int              fd_cyc[$];
   int              acc_cyc[$];
   int              fd_cnt = 0;
   int              acc_cnt = 0;
   int              hold_err = 0;
   logic            prev_valid = 1'b0;
   logic            prev_xfer = 1'b0;
   logic [7:0]      prev_data = 8'h00;

   always @(posedge clk) cyc++;

   // Port observer: records transfers, accepts, frame_done pulses, hold violations.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_xfer  = 1'b0;
      end else begin
         if (prev_valid && !prev_xfer && (!tx_valid || tx_data !== prev_data))
            hold_err++;
         if (tx_valid && tx_require) got.push_back(tx_data);
         if (frame_done) begin fd_cnt++; fd_cyc.push_back(cyc); end
         if (blk_valid && blk_ready) begin acc_cnt++; acc_cyc.push_back(cyc); end
         prev_valid = tx_valid;
         prev_xfer  = tx_valid && tx_require;
         prev_data  = tx_data;
      end
   end

   // Reference frame: header, bytes 0..NB-1 MSB-first, optional XOR of data bytes.
   function automatic void add_frame(input logic [8*NB-1:0] b);
      logic [7:0] x;
      logic [7:0] c;
      c = 8'h00;
      exp.push_back(8'hA5);
      for (int k = 0; k < int'(NB); k++) begin
         x = b[8*NB - 8*k - 1 -: 8];
         exp.push_back(x);
         c = c ^ x;
      end
`ifdef TX_CSUM_EN
      exp.push_back(c);
`endif
   endfunction

   task automatic clear_logs();
      got.delete(); exp.delete(); fd_cyc.delete(); acc_cyc.delete();
      fd_cnt = 0; acc_cnt = 0; hold_err = 0;
   endtask

   // Stimulus driver: offers queued blocks, drives tx_require per mode, optional busy noise.
   task automatic run(input int req_mode, input int want, input int extra, input int noise);
      int budget;
      int popped;
      budget = 6000;
      popped = acc_cnt;
      forever begin
         @(posedge clk); #1;
         while (acc_cnt > popped) begin pend.delete(0); popped++; end
         if (got.size() >= want && pend.size() == 0) break;
         budget--;
         if (budget == 0) begin
            total++; bad++;
            $display("FAIL run_timeout: got %0d bytes, required %0d", got.size(), want);
            break;
         end
         if (req_mode == 0) tx_require = 1'b1;
         else if (req_mode == 1) tx_require = ($urandom_range(0, 19) == 0);
         else tx_require = 1'($urandom_range(0, 1));
         if (pend.size() != 0) begin
            blk_valid = 1'b1;
            blk_data  = pend[0];
         end else if (noise != 0 && busy) begin
            blk_valid = 1'($urandom_range(0, 1));
            blk_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         end else begin
            blk_valid = 1'b0;
         end
      end
      blk_valid = 1'b0;
      repeat (extra) begin @(posedge clk); #1; tx_require = 1'b1; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL reset_blk_ready: got %b want 1", blk_ready); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
   endtask

   task automatic test_basic();
      logic [8*NB-1:0] b;
      clear_logs();
      b = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      add_frame(b); pend.push_back(b);
      run(0, FL, 4, 0);
      total++; if (got.size() != exp.size()) begin bad++; $display("FAIL basic_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
      total++; if (fd_cnt != 1) begin bad++; $display("FAIL basic_frame_done: got %0d want 1", fd_cnt); end
      total++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle: tx_valid=%b busy=%b want 0 0", tx_valid, busy); end
   endtask

   task automatic test_slow_require();
      logic [8*NB-1:0] b;
      clear_logs();
      b = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      add_frame(b); pend.push_back(b);
      run(1, FL, 4, 0);
      total++; if (got.size() != exp.size()) begin bad++; $display("FAIL slow_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL slow_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
      total++; if (hold_err != 0) begin bad++; $display("FAIL slow_hold: got %0d violations want 0", hold_err); end
      total++; if (fd_cnt != 1) begin bad++; $display("FAIL slow_frame_done: got %0d want 1", fd_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [8*NB-1:0] b1;
      logic [8*NB-1:0] b2;
      clear_logs();
      b1 = {NB{8'h01}};
      b2 = {NB{8'h80}};
      add_frame(b1); add_frame(b2);
      pend.push_back(b1); pend.push_back(b2);
      run(0, 2*FL, 4, 0);
      total++; if (got.size() != exp.size()) begin bad++; $display("FAIL b2b_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
      total++; if (fd_cnt != 2) begin bad++; $display("FAIL b2b_frame_done: got %0d want 2", fd_cnt); end
      if (acc_cyc.size() == 2 && fd_cyc.size() >= 1) begin
         total++; if (acc_cyc[1] != fd_cyc[0]) begin bad++; $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_cyc[1], fd_cyc[0]); end
      end else begin
         total++; bad++; $display("FAIL b2b_events: accepts %0d want 2, frame_done %0d", acc_cyc.size(), fd_cyc.size());
      end
   endtask

   task automatic test_csum_pattern();
      logic [8*NB-1:0] b;
      clear_logs();
      for (int k = 0; k < int'(NB); k++) b[8*NB - 8*k - 1 -: 8] = 8'(k + 1);
      add_frame(b); pend.push_back(b);
      run(2, FL, 6, 0);
      total++; if (got.size() != FL) begin bad++; $display("FAIL csum_len: got %0d want %0d", got.size(), FL); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL csum_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
`ifdef TX_CSUM_EN
      if (got.size() == FL) begin
         total++; if (got[FL-1] !== 8'h10) begin bad++; $display("FAIL csum_value: got %h want 10", got[FL-1]); end
      end
`endif
      total++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin bad++; $display("FAIL csum_idle: busy=%b tx_valid=%b want 0 0", busy, tx_valid); end
   endtask

   task automatic test_reset_mid_frame();
      logic [8*NB-1:0] b;
      clear_logs();
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      pend.push_back(b);
      run(0, 5, 0, 0);
      rst = 1'b1;
      #1;
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_tx_valid: got %b want 0", tx_valid); end
      total++; if (blk_ready !== 1'b1) begin bad++; $display("FAIL midrst_blk_ready: got %b want 1", blk_ready); end
      total++; if (fd_cnt != 0) begin bad++; $display("FAIL midrst_frame_done: got %0d want 0", fd_cnt); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_logs();
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      add_frame(b); pend.push_back(b);
      run(0, FL, 4, 0);
      total++; if (got.size() != exp.size()) begin bad++; $display("FAIL midrst_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL midrst_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_busy_noise();
      logic [8*NB-1:0] b;
      for (int f = 0; f < 3; f++) begin
         clear_logs();
         b = {$urandom(), $urandom(), $urandom(), $urandom()};
         add_frame(b); pend.push_back(b);
         run(2, FL, 4, 1);
         total++; if (acc_cnt != 1) begin bad++; $display("FAIL noise_accepts%0d: got %0d want 1", f, acc_cnt); end
         total++; if (got.size() != exp.size()) begin bad++; $display("FAIL noise_len%0d: got %0d want %0d", f, got.size(), exp.size()); end
         for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL noise_f%0d_byte%0d: got %h want %h", f, i, got[i], exp[i]); end
         end
         total++; if (hold_err != 0) begin bad++; $display("FAIL noise_hold%0d: got %0d want 0", f, hold_err); end
      end
   endtask

   task automatic test_random_stream();
      logic [8*NB-1:0] b;
      clear_logs();
      for (int f = 0; f < 4; f++) begin
         b = {$urandom(), $urandom(), $urandom(), $urandom()};
         add_frame(b); pend.push_back(b);
      end
      run(2, 4*FL, 4, 0);
      total++; if (got.size() != exp.size()) begin bad++; $display("FAIL rand_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL rand_byte%0d: got %h want %h", i, got[i], exp[i]); end
      end
      total++; if (fd_cnt != 4) begin bad++; $display("FAIL rand_frame_done: got %0d want 4", fd_cnt); end
      total++; if (hold_err != 0) begin bad++; $display("FAIL rand_hold: got %0d want 0", hold_err); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_slow_require();
      test_back_to_back();
      test_csum_pattern();
      test_reset_mid_frame();
      test_busy_noise();
      test_random_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
